// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard control unit and pipeline top
package hazard_pkg;

  localparam int FWD_NONE = 0;

  // Control-bit ordering of the stall/flush vector shared with the pipeline top
  localparam int CTRL_STALL_F = 0;
  localparam int CTRL_STALL_D = 1;
  localparam int CTRL_FLUSH_D = 2;
  localparam int CTRL_FLUSH_E = 3;
  localparam int CTRL_W       = 4;

  function automatic int selW(input int fwdStages);
    return $clog2(fwdStages + 1);
  endfunction

  // Post-Execute stage k (0 = MEM) forwards on select value k+1
  function automatic int stageSel(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline-side hazard signals grouped for the control unit
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2
);
  import hazard_pkg::*;
  localparam int SEL_W = selW(FWD_STAGES);

  logic [NUM_SRC*REG_ADDR_W-1:0]    rs_d;
  logic [NUM_SRC-1:0]               rs_valid_d;
  logic [REG_ADDR_W-1:0]            rd_d;
  logic                             wr_d;
  logic                             mc_d;
  logic [NUM_SRC*REG_ADDR_W-1:0]    rs_e;
  logic [NUM_SRC-1:0]               rs_valid_e;
  logic [REG_ADDR_W-1:0]            rd_e;
  logic                             wr_e;
  logic                             load_e;
  logic                             mc_issue_e;
  logic [FWD_STAGES*REG_ADDR_W-1:0] rd_stage;
  logic [FWD_STAGES-1:0]            wr_stage;
  logic                             mc_busy;
  logic                             mc_done;
  logic [REG_ADDR_W-1:0]            mc_rd_done;
  logic                             redirect_e;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel;
  logic                             stall_f;
  logic                             stall_d;
  logic                             flush_d;
  logic                             flush_e;

  modport master (
    output rs_d, rs_valid_d, rd_d, wr_d, mc_d, rs_e, rs_valid_e, rd_e, wr_e, load_e,
           mc_issue_e, rd_stage, wr_stage, mc_busy, mc_done, mc_rd_done, redirect_e,
    input  fwd_sel, stall_f, stall_d, flush_d, flush_e
  );

  modport slave (
    input  rs_d, rs_valid_d, rd_d, wr_d, mc_d, rs_e, rs_valid_e, rd_e, wr_e, load_e,
           mc_issue_e, rd_stage, wr_stage, mc_busy, mc_done, mc_rd_done, redirect_e,
    output fwd_sel, stall_f, stall_d, flush_d, flush_e
  );

endinterface

// File: rtl/hazard_ctrl_unit_mc_scoreboard.sv
// rtl/hazard_ctrl_unit_mc_scoreboard.sv - busy bits for registers awaiting a mul/div writeback
module mc_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          setEn,
  input  logic [REG_ADDR_W-1:0]         setAddr,
  input  logic                          clrEn,
  input  logic [REG_ADDR_W-1:0]         clrAddr,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rsAddr,
  input  logic [NUM_SRC-1:0]            rsValid,
  input  logic [REG_ADDR_W-1:0]         rdAddr,
  output logic                          srcBusy,
  output logic                          dstBusy
);

  logic [2**REG_ADDR_W-1:0] busy;

  // Set is applied after clear so a reissue to the retiring register stays busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clrEn) busy[clrAddr] <= 1'b0;
      if (setEn && setAddr != '0) busy[setAddr] <= 1'b1;
    end
  end

  always_comb begin
    srcBusy = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rsValid[i] && busy[rsAddr[i*REG_ADDR_W +: REG_ADDR_W]]) srcBusy = 1'b1;
    end
  end

  assign dstBusy = busy[rdAddr];

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - RAW forwarding selects plus stall/flush sequencing for the 5-stage core
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int FWD_STAGES   = 2,
  parameter int LOAD_LAT     = 1,
  parameter int REDIRECT_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  hazard_ctrl_unit_if.slave hz
);

  localparam int SEL_W = selW(FWD_STAGES);
  localparam int LD_W  = $clog2(LOAD_LAT + 1);
  localparam int RD_W  = $clog2(REDIRECT_LAT + 2);

  logic [LD_W-1:0]   ldCnt;
  logic [RD_W-1:0]   redirCnt;
  logic              rdMatch;
  logic              ldHit;
  logic              ldStall;
  logic              srcBusy;
  logic              dstBusy;
  logic              sbStall;
  logic              stall;
  logic [CTRL_W-1:0] ctrl;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gFwd
    logic [REG_ADDR_W-1:0] rsE;
    logic [SEL_W-1:0]      sel;
    assign rsE = hz.rs_e[i*REG_ADDR_W +: REG_ADDR_W];

    // Walk from the farthest stage so the nearest match is the last one written
    always_comb begin
      sel = SEL_W'(FWD_NONE);
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (hz.wr_stage[k] && hz.rd_stage[k*REG_ADDR_W +: REG_ADDR_W] == rsE &&
            rsE != '0 && hz.rs_valid_e[i]) begin
          sel = SEL_W'(stageSel(k));
        end
      end
    end

    assign hz.fwd_sel[i*SEL_W +: SEL_W] = sel;
  end

  always_comb begin
    rdMatch = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hz.rs_valid_d[i] && hz.rs_d[i*REG_ADDR_W +: REG_ADDR_W] == hz.rd_e) rdMatch = 1'b1;
    end
  end

  assign ldHit   = hz.load_e & hz.wr_e & (hz.rd_e != '0) & rdMatch;
  assign ldStall = ldHit | (ldCnt != '0);

  // The hit cycle itself is the first bubble, so the counter covers the remaining LOAD_LAT-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldCnt    <= '0;
      redirCnt <= '0;
    end else if (hz.redirect_e) begin
      ldCnt    <= '0;
      redirCnt <= RD_W'(REDIRECT_LAT);
    end else begin
      if (ldHit) ldCnt <= LD_W'(LOAD_LAT - 1);
      else if (ldCnt != '0) ldCnt <= ldCnt - LD_W'(1);
      if (redirCnt != '0) redirCnt <= redirCnt - RD_W'(1);
    end
  end

  mc_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_SRC    (NUM_SRC)
  ) uScoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .setEn   (hz.mc_issue_e),
    .setAddr (hz.rd_e),
    .clrEn   (hz.mc_done),
    .clrAddr (hz.mc_rd_done),
    .rsAddr  (hz.rs_d),
    .rsValid (hz.rs_valid_d),
    .rdAddr  (hz.rd_d),
    .srcBusy (srcBusy),
    .dstBusy (dstBusy)
  );

  assign sbStall = srcBusy | (hz.wr_d & dstBusy) | (hz.mc_d & hz.mc_busy);
  assign stall   = (ldStall | sbStall) & ~hz.redirect_e;

  always_comb begin
    ctrl               = '0;
    ctrl[CTRL_STALL_F] = stall;
    ctrl[CTRL_STALL_D] = stall;
    ctrl[CTRL_FLUSH_D] = hz.redirect_e | (redirCnt != '0);
    ctrl[CTRL_FLUSH_E] = stall | hz.redirect_e;
  end

  assign hz.stall_f = ctrl[CTRL_STALL_F];
  assign hz.stall_d = ctrl[CTRL_STALL_D];
  assign hz.flush_d = ctrl[CTRL_FLUSH_D];
  assign hz.flush_e = ctrl[CTRL_FLUSH_E];

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic [9:0] rsD;
    logic [1:0] rsValidD;
    logic [4:0] rdD;
    logic       wrD;
    logic       mcD;
    logic [9:0] rsE;
    logic [1:0] rsValidE;
    logic [4:0] rdE;
    logic       wrE;
    logic       loadE;
    logic       mcIssueE;
    logic [9:0] rdStage;
    logic [1:0] wrStage;
    logic       mcBusy;
    logic       mcDone;
    logic [4:0] mcRdDone;
    logic       redirectE;
  } vec_t;

  typedef struct {
    logic [3:0] fwd;
    logic       stall;
    logic       flushD;
    logic       flushE;
    string      name;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFails = 0;
  exp_t sbq[$];
  rec_t tbl[10];

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_STAGES(2)) hz();

  hazard_ctrl_unit #(
    .REG_ADDR_W   (5),
    .NUM_SRC      (2),
    .FWD_STAGES   (2),
    .LOAD_LAT     (2),
    .REDIRECT_LAT (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  function automatic exp_t mk(logic [3:0] fwd, logic st, logic fd, logic fe, string name);
    exp_t e;
    e.fwd = fwd; e.stall = st; e.flushD = fd; e.flushE = fe; e.name = name;
    return e;
  endfunction

  task automatic apply(input vec_t v);
    hz.rs_d = v.rsD; hz.rs_valid_d = v.rsValidD; hz.rd_d = v.rdD; hz.wr_d = v.wrD;
    hz.mc_d = v.mcD; hz.rs_e = v.rsE; hz.rs_valid_e = v.rsValidE; hz.rd_e = v.rdE;
    hz.wr_e = v.wrE; hz.load_e = v.loadE; hz.mc_issue_e = v.mcIssueE;
    hz.rd_stage = v.rdStage; hz.wr_stage = v.wrStage; hz.mc_busy = v.mcBusy;
    hz.mc_done = v.mcDone; hz.mc_rd_done = v.mcRdDone; hz.redirect_e = v.redirectE;
  endtask

  task automatic chk1(input string name, input string sig, input logic [3:0] act, input logic [3:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s.%s actual=%h expected=%h", name, sig, act, exp);
    end
  endtask

  task automatic checkOut();
    exp_t e;
    if (sbq.size() == 0) begin
      nChecks++; nFails++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sbq.pop_front();
    chk1(e.name, "fwd_sel", hz.fwd_sel, e.fwd);
    chk1(e.name, "stall_f", {3'b0, hz.stall_f}, {3'b0, e.stall});
    chk1(e.name, "stall_d", {3'b0, hz.stall_d}, {3'b0, e.stall});
    chk1(e.name, "flush_d", {3'b0, hz.flush_d}, {3'b0, e.flushD});
    chk1(e.name, "flush_e", {3'b0, hz.flush_e}, {3'b0, e.flushE});
  endtask

  task automatic cyc(input vec_t v, input exp_t e);
    @(posedge clk);
    #1;
    apply(v);
    sbq.push_back(e);
    @(negedge clk);
    checkOut();
  endtask

  task automatic now(input exp_t e);
    sbq.push_back(e);
    #1;
    checkOut();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t z;
    z = '0;

    for (int i = 0; i < 10; i++) tbl[i].v = '0;
    tbl[0].e = mk(4'h0, 0, 0, 0, "fwd_idle");
    tbl[1].v.rsE = {5'd0, 5'd5}; tbl[1].v.rsValidE = 2'b11; tbl[1].v.wrStage = 2'b11;
    tbl[1].v.rdStage = {5'd5, 5'd5};
    tbl[1].e = mk(4'b0001, 0, 0, 0, "fwd_mem_wins");
    tbl[2].v = tbl[1].v; tbl[2].v.rsE = {5'd0, 5'd0};
    tbl[2].e = mk(4'b0000, 0, 0, 0, "fwd_x0");
    tbl[3].v.rsE = {5'd5, 5'd5}; tbl[3].v.rsValidE = 2'b11; tbl[3].v.wrStage = 2'b10;
    tbl[3].v.rdStage = {5'd5, 5'd5};
    tbl[3].e = mk(4'b1010, 0, 0, 0, "fwd_wb_only");
    tbl[4].v.rsE = {5'd6, 5'd5}; tbl[4].v.rsValidE = 2'b10; tbl[4].v.wrStage = 2'b11;
    tbl[4].v.rdStage = {5'd5, 5'd6};
    tbl[4].e = mk(4'b0100, 0, 0, 0, "fwd_invalid_src");
    tbl[5].v.rsE = {5'd9, 5'd3}; tbl[5].v.rsValidE = 2'b11; tbl[5].v.wrStage = 2'b10;
    tbl[5].v.rdStage = {5'd9, 5'd9};
    tbl[5].e = mk(4'b1000, 0, 0, 0, "fwd_mem_nowrite");
    tbl[6].v.rsE = {5'd7, 5'd7}; tbl[6].v.rsValidE = 2'b11; tbl[6].v.wrStage = 2'b11;
    tbl[6].v.rdStage = {5'd7, 5'd8};
    tbl[6].e = mk(4'b1010, 0, 0, 0, "fwd_both_wb");
    tbl[7].v.loadE = 1; tbl[7].v.wrE = 1; tbl[7].v.rdE = 5'd7;
    tbl[7].v.rsD = {5'd8, 5'd7}; tbl[7].v.rsValidD = 2'b10;
    tbl[7].e = mk(4'h0, 0, 0, 0, "load_no_hit");
    tbl[8].v.loadE = 1; tbl[8].v.wrE = 1; tbl[8].v.rdE = 5'd0;
    tbl[8].v.rsD = {5'd0, 5'd0}; tbl[8].v.rsValidD = 2'b11;
    tbl[8].e = mk(4'h0, 0, 0, 0, "load_x0");
    tbl[9].v.loadE = 1; tbl[9].v.wrE = 0; tbl[9].v.rdE = 5'd7;
    tbl[9].v.rsD = {5'd0, 5'd7}; tbl[9].v.rsValidD = 2'b01;
    tbl[9].e = mk(4'h0, 0, 0, 0, "load_nowrite");

    apply(z);
    now(mk(4'h0, 0, 0, 0, "reset_state"));
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) cyc(tbl[i].v, tbl[i].e);

    // Load-use with LOAD_LAT=2
    v = z; v.loadE = 1; v.wrE = 1; v.rdE = 5'd7; v.rsD = {5'd7, 5'd0}; v.rsValidD = 2'b10;
    cyc(v, mk(4'h0, 1, 0, 1, "ld_use_c0"));
    v = z; v.rsD = {5'd7, 5'd0}; v.rsValidD = 2'b10;
    cyc(v, mk(4'h0, 1, 0, 1, "ld_use_c1"));
    cyc(v, mk(4'h0, 0, 0, 0, "ld_use_c2"));

    // Scoreboard RAW on reg 9
    v = z; v.mcIssueE = 1; v.wrE = 1; v.rdE = 5'd9;
    cyc(v, mk(4'h0, 0, 0, 0, "sb_issue9"));
    v = z; v.rsD = {5'd0, 5'd9}; v.rsValidD = 2'b01;
    cyc(v, mk(4'h0, 1, 0, 1, "sb_raw_c1"));
    cyc(v, mk(4'h0, 1, 0, 1, "sb_raw_c2"));
    v.mcDone = 1; v.mcRdDone = 5'd9;
    cyc(v, mk(4'h0, 1, 0, 1, "sb_done_cycle"));
    v.mcDone = 0;
    cyc(v, mk(4'h0, 0, 0, 0, "sb_released"));

    // Reissue in the same cycle as completion keeps the register busy
    v = z; v.mcIssueE = 1; v.wrE = 1; v.rdE = 5'd9;
    cyc(v, mk(4'h0, 0, 0, 0, "set_issue"));
    v.mcDone = 1; v.mcRdDone = 5'd9;
    cyc(v, mk(4'h0, 0, 0, 0, "set_and_clear"));
    v = z; v.rsD = {5'd0, 5'd9}; v.rsValidD = 2'b01;
    cyc(v, mk(4'h0, 1, 0, 1, "set_wins"));
    v.mcDone = 1; v.mcRdDone = 5'd9;
    cyc(v, mk(4'h0, 1, 0, 1, "set_clear2"));
    v.mcDone = 0;
    cyc(v, mk(4'h0, 0, 0, 0, "set_released"));

    // WAW, x0 and structural hazards
    v = z; v.mcIssueE = 1; v.wrE = 1; v.rdE = 5'd3;
    cyc(v, mk(4'h0, 0, 0, 0, "waw_issue3"));
    v = z; v.wrD = 1; v.rdD = 5'd3;
    cyc(v, mk(4'h0, 1, 0, 1, "waw_stall"));
    v.wrD = 0;
    cyc(v, mk(4'h0, 0, 0, 0, "waw_nowrite"));
    v = z; v.mcDone = 1; v.mcRdDone = 5'd3; v.mcIssueE = 1; v.rdE = 5'd0;
    cyc(v, mk(4'h0, 0, 0, 0, "waw_clear_x0issue"));
    v = z; v.rsD = {5'd3, 5'd0}; v.rsValidD = 2'b11; v.wrD = 1; v.rdD = 5'd0;
    cyc(v, mk(4'h0, 0, 0, 0, "x0_never_busy"));
    v = z; v.mcD = 1; v.mcBusy = 1;
    cyc(v, mk(4'h0, 1, 0, 1, "struct_c0"));
    cyc(v, mk(4'h0, 1, 0, 1, "struct_c1"));
    v.mcBusy = 0;
    cyc(v, mk(4'h0, 0, 0, 0, "struct_free"));
    v = z; v.mcBusy = 1;
    cyc(v, mk(4'h0, 0, 0, 0, "busy_no_mc"));

    // Redirect in the load-use hit cycle
    v = z; v.loadE = 1; v.wrE = 1; v.rdE = 5'd7; v.rsD = {5'd7, 5'd0}; v.rsValidD = 2'b10;
    v.redirectE = 1;
    cyc(v, mk(4'h0, 0, 1, 1, "redir_ld_c0"));
    v = z; v.rsD = {5'd7, 5'd0}; v.rsValidD = 2'b10;
    cyc(v, mk(4'h0, 0, 1, 0, "redir_ld_c1"));
    cyc(v, mk(4'h0, 0, 0, 0, "redir_ld_c2"));
    v = z; v.redirectE = 1;
    cyc(v, mk(4'h0, 0, 1, 1, "redir_a"));
    cyc(v, mk(4'h0, 0, 1, 1, "redir_reload"));
    v = z;
    cyc(v, mk(4'h0, 0, 1, 0, "redir_hold"));
    cyc(v, mk(4'h0, 0, 0, 0, "redir_done"));

    // Asynchronous reset with busy[4] and ld_cnt live
    v = z; v.mcIssueE = 1; v.wrE = 1; v.rdE = 5'd4;
    cyc(v, mk(4'h0, 0, 0, 0, "rst_issue4"));
    v = z; v.loadE = 1; v.wrE = 1; v.rdE = 5'd7; v.rsD = {5'd7, 5'd0}; v.rsValidD = 2'b10;
    cyc(v, mk(4'h0, 1, 0, 1, "rst_ld_hit"));
    @(posedge clk);
    #1;
    v = z; v.rsD = {5'd0, 5'd4}; v.rsValidD = 2'b01;
    apply(v);
    now(mk(4'h0, 1, 0, 1, "rst_pre"));
    rst_n = 1'b0;
    now(mk(4'h0, 0, 0, 0, "rst_async_busy"));
    apply(z);
    now(mk(4'h0, 0, 0, 0, "rst_async_idle"));
    rst_n = 1'b1;

    // Asynchronous reset with redir_cnt live
    v = z; v.redirectE = 1;
    cyc(v, mk(4'h0, 0, 1, 1, "rst_redir"));
    @(posedge clk);
    #1;
    apply(z);
    now(mk(4'h0, 0, 1, 0, "rst_redir_pre"));
    rst_n = 1'b0;
    now(mk(4'h0, 0, 0, 0, "rst_redir_async"));
    #1 rst_n = 1'b1;
    cyc(z, mk(4'h0, 0, 0, 0, "post_reset_idle"));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
